// File: rtl/tbus_arbiter_pkg.sv
// Shared TBUS types: request/response structs, transfer-size codes,
// owner encoding and the arbiter FSM state type.
package tbus_arbiter_pkg;

  localparam logic [1:0] MSIZE1 = 2'b00;
  localparam logic [1:0] MSIZE2 = 2'b01;
  localparam logic [1:0] MSIZE4 = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic        is_uncached;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } tbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } tbus_resp_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  // State codes line up with the owner encoding so owned states read the same on both.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_I = 2'b01,
    ST_OWN_D = 2'b10
  } tbus_state_e;

endpackage

// File: rtl/tbus_arbiter.sv
// Two-master TBUS arbiter: I-cache and D-cache share one memory-side bus,
// round-robin between them, ownership held from grant until data_ok.
import tbus_arbiter_pkg::*;

module tbus_arbiter #(
  parameter logic RR_INIT_D = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  tbus_req_t   itreq,
  output tbus_resp_t  itresp,
  input  tbus_req_t   dtreq,
  output tbus_resp_t  dtresp,
  output tbus_req_t   mreq,
  input  tbus_resp_t  mresp,
  output logic [1:0]  owner,
  output tbus_state_e state
);

  // Handshake: a requester raises valid and holds its request stable; the
  // transaction completes on the single cycle where mresp.data_ok is high
  // while that requester is selected. There is no separate ready signal.

  tbus_state_e state_q;
  tbus_state_e state_d;
  logic        rr_q;
  logic        sel_i;
  logic        sel_d;
  logic        done;

  // In IDLE the winner is chosen combinationally so the grant costs no cycle.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_OWN_I: sel_i = 1'b1;
        ST_OWN_D: sel_d = 1'b1;
        default: begin
          sel_d = dtreq.valid && (!itreq.valid || rr_q);
          sel_i = itreq.valid && !sel_d;
        end
      endcase
    end
  end

  assign done = (sel_i || sel_d) && mresp.data_ok;

  always_comb begin
    state_d = state_q;
    if (done) begin
      state_d = ST_IDLE;
    end else if (sel_i) begin
      state_d = ST_OWN_I;
    end else if (sel_d) begin
      state_d = ST_OWN_D;
    end
  end

  // After a completion the pointer favours the side that did not just finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= RR_INIT_D;
    end else begin
      state_q <= state_d;
      if (done) begin
        rr_q <= sel_i;
      end
    end
  end

  always_comb begin
    mreq = '0;
    if (sel_i) begin
      mreq = itreq;
    end else if (sel_d) begin
      mreq = dtreq;
    end
    itresp         = mresp;
    itresp.data_ok = mresp.data_ok && sel_i;
    itresp.addr_ok = mresp.addr_ok && sel_i;
    dtresp         = mresp;
    dtresp.data_ok = mresp.data_ok && sel_d;
    dtresp.addr_ok = mresp.addr_ok && sel_d;
  end

  assign owner = {sel_d, sel_i};
  assign state = reset ? ST_IDLE : state_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level ownership model.
module tb_tbus_arbiter;
  import tbus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  tbus_req_t   itreq;
  tbus_req_t   dtreq;
  tbus_req_t   mreq;
  tbus_resp_t  itresp;
  tbus_resp_t  dtresp;
  tbus_resp_t  mresp;
  logic [1:0]  owner;
  tbus_state_e state;

  int checks = 0;
  int errors = 0;

  // Model: who holds the bus (0 none, 1 I, 2 D) and who wins a tie (1 = D).
  int m_owner = 0;
  int m_rr    = 1;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  tbus_arbiter #(.RR_INIT_D(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .itreq  (itreq),
    .itresp (itresp),
    .dtreq  (dtreq),
    .dtresp (dtresp),
    .mreq   (mreq),
    .mresp  (mresp),
    .owner  (owner),
    .state  (state)
  );

  function automatic int model_owner();
    if (reset) return 0;
    if (m_owner != 0) return m_owner;
    if (itreq.valid && dtreq.valid) return (m_rr != 0) ? 2 : 1;
    if (dtreq.valid) return 2;
    if (itreq.valid) return 1;
    return 0;
  endfunction

  function automatic tbus_req_t exp_mreq(input int e);
    if (e == 1) return itreq;
    if (e == 2) return dtreq;
    return '0;
  endfunction

  function automatic tbus_resp_t exp_resp(input int e, input int who);
    tbus_resp_t r = mresp;
    r.data_ok = mresp.data_ok && (e == who);
    r.addr_ok = mresp.addr_ok && (e == who);
    return r;
  endfunction

  task automatic model_commit();
    int e = model_owner();
    if (reset) begin
      m_owner = 0;
      m_rr    = 1;
    end else if (e != 0 && mresp.data_ok) begin
      m_owner = 0;
      m_rr    = (e == 1) ? 1 : 0;
    end else begin
      m_owner = e;
    end
  endtask

  function automatic tbus_req_t mk_rd(input logic [31:0] a);
    tbus_req_t r = '0;
    r.valid = 1'b1;
    r.size  = MSIZE4;
    r.addr  = a;
    return r;
  endfunction

  function automatic tbus_req_t mk_rand(input logic v);
    tbus_req_t r;
    r.valid       = v;
    r.is_write    = 1'($urandom_range(0, 1));
    r.is_uncached = 1'($urandom_range(0, 1));
    r.size        = 2'($urandom_range(0, 2));
    r.addr        = $urandom;
    r.strobe      = 4'($urandom_range(0, 15));
    r.data        = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    tick();
    itreq = '0;
    dtreq = '0;
    mresp = '0;
    #2;
    model_commit();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    itreq = mk_rd(32'h2000);
    dtreq = mk_rd(32'h1000);
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hdead_beef};
    for (int c = 0; c < 2; c++) begin
      tick();
      #2;
      checks++; if (mreq.valid !== 1'b0) begin errors++; $display("FAIL reset_mreq_valid: got %b want 0", mreq.valid); end
      checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b want 00", owner); end
      checks++; if (itresp.data_ok !== 1'b0) begin errors++; $display("FAIL reset_i_data_ok: got %b want 0", itresp.data_ok); end
      checks++; if (dtresp.data_ok !== 1'b0) begin errors++; $display("FAIL reset_d_data_ok: got %b want 0", dtresp.data_ok); end
      checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
      model_commit();
    end
  endtask

  task automatic test_first_grant();
    tick();
    reset = 1'b0;
    mresp = '0;
    #2;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL first_owner: got %b want 10", owner); end
    checks++; if (mreq.addr !== 32'h1000) begin errors++; $display("FAIL first_addr: got %h want 00001000", mreq.addr); end
    model_commit();
    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      checks++; if (mreq !== dtreq) begin errors++; $display("FAIL first_hold: got %h want %h", mreq, dtreq); end
      checks++; if (dtresp.data_ok !== 1'b0) begin errors++; $display("FAIL first_early_ok: got %b want 0", dtresp.data_ok); end
      model_commit();
    end
    tick();
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1234_5678};
    #2;
    checks++; if (dtresp.data_ok !== 1'b1) begin errors++; $display("FAIL first_d_ok: got %b want 1", dtresp.data_ok); end
    checks++; if (itresp.data_ok !== 1'b0) begin errors++; $display("FAIL first_i_ok: got %b want 0", itresp.data_ok); end
    checks++; if (itresp.data !== 32'h1234_5678) begin errors++; $display("FAIL first_bcast: got %h want 12345678", itresp.data); end
    model_commit();
    tick();
    dtreq = '0;
    mresp = '0;
    #2;
    checks++; if (mreq.addr !== 32'h2000) begin errors++; $display("FAIL second_addr: got %h want 00002000", mreq.addr); end
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL second_owner: got %b want 01", owner); end
    checks++; if (dtresp.data_ok !== 1'b0) begin errors++; $display("FAIL first_ok_len: got %b want 0", dtresp.data_ok); end
    model_commit();
    tick();
    mresp.data_ok = 1'b1;
    #2;
    model_commit();
    idle_cycle();
  endtask

  task automatic test_contention();
    int done_n = 0;
    int e;
    logic [1:0] want;
    logic refresh_i = 1'b0;
    logic refresh_d = 1'b0;
    exp_q = {2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 100 && done_n < 6; c++) begin
      tick();
      if (c == 0 || refresh_i) itreq = mk_rd($urandom);
      if (c == 0 || refresh_d) dtreq = mk_rd($urandom);
      refresh_i = 1'b0;
      refresh_d = 1'b0;
      mresp = '0;
      mresp.data = $urandom;
      mresp.data_ok = ($urandom_range(0, 2) == 0);
      #2;
      e = model_owner();
      checks++; if (owner !== 2'(e)) begin errors++; $display("FAIL contention_owner: got %b want %b", owner, 2'(e)); end
      if (mresp.data_ok && e != 0) begin
        want = exp_q.pop_front();
        checks++; if (owner !== want) begin errors++; $display("FAIL contention_order: got %b want %b", owner, want); end
        done_n++;
        refresh_i = (e == 1);
        refresh_d = (e == 2);
      end
      model_commit();
    end
    checks++; if (done_n != 6) begin errors++; $display("FAIL contention_timeout: got %0d want 6 completions", done_n); end
    idle_cycle();
  endtask

  task automatic test_zero_latency();
    tick();
    dtreq = mk_rd(32'h4000);
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    #2;
    checks++; if (dtresp.data_ok !== 1'b1) begin errors++; $display("FAIL zl_d_ok: got %b want 1", dtresp.data_ok); end
    model_commit();
    tick();
    dtreq = '0;
    itreq = mk_rd(32'h5000);
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hcafe_0001};
    #2;
    checks++; if (itresp.data_ok !== 1'b1) begin errors++; $display("FAIL zl_i_ok: got %b want 1", itresp.data_ok); end
    checks++; if (itresp.addr_ok !== 1'b1) begin errors++; $display("FAIL zl_i_addr_ok: got %b want 1", itresp.addr_ok); end
    checks++; if (dtresp.addr_ok !== 1'b0) begin errors++; $display("FAIL zl_d_addr_ok: got %b want 0", dtresp.addr_ok); end
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL zl_owner: got %b want 01", owner); end
    model_commit();
    tick();
    itreq = mk_rd(32'h6000);
    dtreq = mk_rd(32'h7000);
    mresp = '0;
    #2;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL zl_rr_d: got %b want 10", owner); end
    checks++; if (mreq !== dtreq) begin errors++; $display("FAIL zl_mreq: got %h want %h", mreq, dtreq); end
    model_commit();
    tick();
    mresp.data_ok = 1'b1;
    #2;
    model_commit();
    tick();
    dtreq = '0;
    #2;
    model_commit();
    idle_cycle();
  endtask

  task automatic test_late_requester();
    tbus_req_t wb = '0;
    wb.valid = 1'b1;
    wb.is_write = 1'b1;
    wb.size = MSIZE4;
    wb.strobe = 4'b1111;
    wb.addr = 32'h0000_8040;
    wb.data = $urandom;
    for (int c = 0; c < 5; c++) begin
      tick();
      dtreq = wb;
      itreq = (c >= 1) ? mk_rd(32'h3000) : '0;
      mresp = '0;
      mresp.data = $urandom;
      mresp.data_ok = (c == 4);
      #2;
      checks++; if (mreq !== wb) begin errors++; $display("FAIL late_mreq: got %h want %h", mreq, wb); end
      checks++; if (itresp.data_ok !== 1'b0) begin errors++; $display("FAIL late_i_ok: got %b want 0", itresp.data_ok); end
      model_commit();
    end
    tick();
    dtreq = '0;
    mresp = '0;
    #2;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL late_grant: got %b want 01", owner); end
    checks++; if (mreq.addr !== 32'h3000) begin errors++; $display("FAIL late_addr: got %h want 00003000", mreq.addr); end
    model_commit();
    tick();
    mresp.data_ok = 1'b1;
    #2;
    model_commit();
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    tick();
    dtreq = mk_rd(32'h9000);
    mresp = '0;
    mresp.data_ok = 1'b1;
    #2;
    model_commit();
    tick();
    dtreq = mk_rd(32'ha000);
    itreq = mk_rd(32'hb000);
    mresp = '0;
    #2;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL rmid_i_grant: got %b want 01", owner); end
    model_commit();
    tick();
    #2;
    model_commit();
    tick();
    reset = 1'b1;
    #2;
    checks++; if (mreq.valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", mreq.valid); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rmid_owner: got %b want 00", owner); end
    model_commit();
    tick();
    reset = 1'b0;
    #2;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL rmid_d_first: got %b want 10", owner); end
    checks++; if (mreq !== dtreq) begin errors++; $display("FAIL rmid_mreq: got %h want %h", mreq, dtreq); end
    model_commit();
    tick();
    mresp.data_ok = 1'b1;
    #2;
    model_commit();
    tick();
    dtreq = '0;
    #2;
    model_commit();
    idle_cycle();
  endtask

  task automatic test_uncached();
    tbus_req_t u = '0;
    u.valid = 1'b1;
    u.is_uncached = 1'b1;
    u.size = MSIZE1;
    u.addr = 32'hbfd0_0003;
    u.strobe = 4'b1000;
    u.data = $urandom;
    for (int c = 0; c < 2; c++) begin
      tick();
      dtreq = u;
      mresp = '0;
      mresp.data = $urandom;
      mresp.data_ok = (c == 1);
      #2;
      checks++; if (mreq !== u) begin errors++; $display("FAIL unc_mreq: got %h want %h", mreq, u); end
      checks++; if (dtresp.data !== mresp.data) begin errors++; $display("FAIL unc_data: got %h want %h", dtresp.data, mresp.data); end
      model_commit();
    end
    idle_cycle();
  endtask

  task automatic test_random();
    logic i_pend = 1'b0;
    logic d_pend = 1'b0;
    int e;
    for (int c = 0; c < 400; c++) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      if (!i_pend) begin
        i_pend = ($urandom_range(0, 2) == 0);
        itreq = mk_rand(i_pend);
      end
      if (!d_pend) begin
        d_pend = ($urandom_range(0, 2) == 0);
        dtreq = mk_rand(d_pend);
      end
      mresp.data = $urandom;
      mresp.addr_ok = 1'($urandom_range(0, 1));
      mresp.data_ok = ($urandom_range(0, 2) == 0);
      #2;
      e = model_owner();
      checks++; if (mreq !== exp_mreq(e)) begin errors++; $display("FAIL rand_mreq c=%0d: got %h want %h", c, mreq, exp_mreq(e)); end
      checks++; if (itresp !== exp_resp(e, 1)) begin errors++; $display("FAIL rand_itresp c=%0d: got %h want %h", c, itresp, exp_resp(e, 1)); end
      checks++; if (dtresp !== exp_resp(e, 2)) begin errors++; $display("FAIL rand_dtresp c=%0d: got %h want %h", c, dtresp, exp_resp(e, 2)); end
      checks++; if (owner !== 2'(e)) begin errors++; $display("FAIL rand_owner c=%0d: got %b want %b", c, owner, 2'(e)); end
      if (mresp.data_ok && e == 1) i_pend = 1'b0;
      if (mresp.data_ok && e == 2) d_pend = 1'b0;
      model_commit();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    itreq = '0;
    dtreq = '0;
    mresp = '0;
    test_reset();
    test_first_grant();
    test_contention();
    test_zero_latency();
    test_late_requester();
    test_reset_mid();
    test_uncached();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
